// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory loader.
//
// Takes a byte stream over valid/ready and writes it into the instruction
// memory. The processor stays in reset until the whole image is written.
// Stream format: LEN_HI, LEN_LO (16-bit word count N), then 4*N payload
// bytes. Each word is sent most-significant byte first.
//
// Optional feature: define IMEM_LOADER_CKSUM_EN to enable checksumming.
// The loader then keeps a running XOR of every accepted byte and expects
// one trailing checksum byte after the payload. On a mismatch it goes to
// the error state. Words already written are left in memory.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse; starts a load from IDLE, DONE or ERR
//   in_valid   byte available on in_data
//   in_data    byte payload
//   in_ready   loader accepts a byte this cycle (registered)
//   mem_we     instruction-memory write strobe, one cycle per word
//   mem_addr   word address; holds its value while mem_we is low
//   mem_wdata  word to write; holds its value while mem_we is low
//   cpu_reset  active-high processor reset
//   done       image loaded (level)
//   error      load aborted (level)
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

`ifdef IMEM_LOADER_CKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CKSUM, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = CKSUM;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t          state;
    state_t          state_nxt;
    logic            take;
    logic            word_done;
    logic            last_word;
    logic [15:0]     len_word;
    logic [7:0]      len_hi_p0;
    logic [15:0]     len_p0;
    logic [23:0]     asm_p0;
    logic [1:0]      byte_cnt;
    logic [AW-1:0]   word_idx;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]      csum_p0;
`endif

    // States in which the loader consumes bytes.
    function automatic logic is_loading(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA)
`ifdef IMEM_LOADER_CKSUM_EN
            || (s == CKSUM)
`endif
            ;
    endfunction

    assign take      = in_valid && in_ready;
    assign len_word  = {len_hi_p0, in_data};
    assign word_done = (state == DATA) && take && (byte_cnt == 2'd3);
    // DATA is only entered with N >= 1, so N-1 cannot underflow here.
    assign last_word = (16'(word_idx) == len_p0 - 16'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
            LEN_HI:          if (take) state_nxt = LEN_LO;
            LEN_LO: begin
                if (take) begin
                    if (len_word > 16'(DEPTH))  state_nxt = ERR;
                    else if (len_word == 16'd0) state_nxt = AFTER_DATA;
                    else                        state_nxt = DATA;
                end
            end
            DATA:            if (word_done && last_word) state_nxt = AFTER_DATA;
`ifdef IMEM_LOADER_CKSUM_EN
            CKSUM:           if (take) state_nxt = (in_data == csum_p0) ? DONE : ERR;
`endif
            default:         state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: byte capture / word assembly (no reset; only read after the capturing byte) ----
    always_ff @(posedge clk) begin
        if (state == LEN_HI && take) len_hi_p0 <= in_data;
        if (state == LEN_LO && take) len_p0 <= len_word;
        if (state == DATA && take)   asm_p0 <= {asm_p0[15:0], in_data};
`ifdef IMEM_LOADER_CKSUM_EN
        // The checksum starts from zero on every load. The trailing byte is compared against it
        // but is not folded into it.
        if (start && !is_loading(state))  csum_p0 <= '0;
        else if (take && state != CKSUM)  csum_p0 <= csum_p0 ^ in_data;
`endif
    end

    // ---- stage p1: control state and registered outputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            byte_cnt  <= '0;
            word_idx  <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= is_loading(state_nxt);
            done      <= (state_nxt == DONE);
            error     <= (state_nxt == ERR);
            // Release the CPU one cycle after done rises, so the final write has committed first.
            cpu_reset <= !((state == DONE) && (state_nxt == DONE));
            mem_we    <= word_done;
            if (state == LEN_LO && take) begin
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (state == DATA && take) byte_cnt <= byte_cnt + 2'd1;
            if (word_done) begin
                mem_addr  <= word_idx;
                mem_wdata <= {asm_p0, in_data};
                word_idx  <= word_idx + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;

    wr_t        exp_q[$];
    wr_t        act_log[$];
    logic [7:0] stream[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         wr_count = 0;
    int         exp_nw = 0;
    bit         exp_done = 0;
    bit         exp_err = 0;
    logic          done_prev = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: derives the expected writes and the final status from the stream format rules.
    task automatic build_model();
        int n;
        exp_q.delete();
        n = int'({stream[0], stream[1]});
        exp_nw = 0; exp_done = 0; exp_err = 0;
        if (n > DEPTH) begin
            exp_err = 1;
            return;
        end
        for (int w = 0; w < n; w++)
            exp_q.push_back({AW'(w), stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]});
        exp_nw = n;
`ifdef IMEM_LOADER_CKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int k = 0; k < 2 + 4*n; k++) x ^= stream[k];
            if (stream[2+4*n] == x) exp_done = 1; else exp_err = 1;
        end
`else
        exp_done = 1;
`endif
    endtask

`ifdef IMEM_LOADER_CKSUM_EN
    task automatic append_cksum();
        logic [7:0] x = 8'h00;
        foreach (stream[k]) x ^= stream[k];
        stream.push_back(x);
    endtask
`endif

    task automatic check_reset_vals(input string p);
        check({p, "_in_ready"},  in_ready, 0);
        check({p, "_mem_we"},    mem_we, 0);
        check({p, "_mem_addr"},  mem_addr, 0);
        check({p, "_mem_wdata"}, mem_wdata, 0);
        check({p, "_cpu_reset"}, cpu_reset, 1);
        check({p, "_done"},      done, 0);
        check({p, "_error"},     error, 0);
    endtask

    task automatic run_load(input string name, input bit gaps, input int limit, input bit extra_start);
        int i = 0;
        int cyc = 0;
        bit acc;
        build_model();
        wr_count = 0;
        act_log.delete();
        while (i < limit && cyc < 2000) begin
            @(negedge clk);
            start = (cyc == 0) || (extra_start && cyc == 6);
            if (gaps && (cyc % 2 == 1)) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data  = stream[i];
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        @(negedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        check({name, "_bytes_taken"}, i, limit);
        if (limit == stream.size()) begin
            if (!gaps) check({name, "_cycles"}, cyc, limit + 1);
            check({name, "_ready_dropped"}, in_ready, 0);
            check({name, "_done"}, done, exp_done);
            check({name, "_error"}, error, exp_err);
            check({name, "_writes"}, wr_count, exp_nw);
            @(negedge clk); #1;
            check({name, "_cpu_reset_after"}, cpu_reset, !exp_done);
            check({name, "_ready_low"}, in_ready, 0);
        end
    endtask

    // Per-cycle compare against the model and the output rules.
    initial begin : compare
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                done_prev  = 1'b0;
                last_addr  = '0;
                last_wdata = '0;
            end else begin
                if (mem_we) begin
                    wr_count++;
                    act_log.push_back({mem_addr, mem_wdata});
                    check("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("write_addr", mem_addr, e.addr);
                        check("write_data", mem_wdata, e.data);
                    end
                    last_addr  = mem_addr;
                    last_wdata = mem_wdata;
                end else begin
                    check("addr_hold", mem_addr, last_addr);
                    check("wdata_hold", mem_wdata, last_wdata);
                end
                check("cpu_reset_rule", cpu_reset, !(done && done_prev));
                check("done_error_exclusive", done && error, 0);
                if (done || error) check("ready_when_stopped", in_ready, 0);
                if (done && !done_prev) begin
                    check("writes_complete_at_done", exp_q.size(), 0);
`ifndef IMEM_LOADER_CKSUM_EN
                    if (exp_nw > 0) check("done_with_last_write", mem_we, 1);
`endif
                end
                done_prev = done;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin : main
        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset");
        @(negedge clk); @(negedge clk); #2 reset_n = 1'b1;
        @(negedge clk); #1 check_reset_vals("idle");

        // Two words, back-to-back; start coincides with the first valid byte.
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef IMEM_LOADER_CKSUM_EN
        append_cksum();
`endif
        run_load("t1", 0, stream.size(), 0);
        check("t1_log_size", act_log.size(), 2);
        if (act_log.size() == 2) begin
            check("t1_w0", act_log[0], {6'd0, 32'h12345678});
            check("t1_w1", act_log[1], {6'd1, 32'h9ABCDEF0});
        end
        check("t1_done_lit", done, 1);
        check("t1_cpu_reset_lit", cpu_reset, 0);

        // Same image with valid low on alternate cycles and a stray start mid-load.
        run_load("t2", 1, stream.size(), 1);
        check("t2_log_size", act_log.size(), 2);
        if (act_log.size() == 2) begin
            check("t2_w0", act_log[0], {6'd0, 32'h12345678});
            check("t2_w1", act_log[1], {6'd1, 32'h9ABCDEF0});
        end

        // Length one beyond DEPTH.
        stream = '{8'h00, 8'h41};
        run_load("t3", 0, stream.size(), 0);
        repeat (3) @(negedge clk);
        #1;
        check("t3_error_lit", error, 1);
        check("t3_cpu_reset_lit", cpu_reset, 1);
        check("t3_ready_lit", in_ready, 0);
        check("t3_no_writes", wr_count, 0);

        // Empty image.
        stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
        append_cksum();
`endif
        run_load("t4", 0, stream.size(), 0);
        check("t4_done_lit", done, 1);
        check("t4_no_writes", wr_count, 0);

`ifdef IMEM_LOADER_CKSUM_EN
        stream = '{8'h00, 8'h00, 8'h01};
        run_load("t4b", 0, stream.size(), 0);
        check("t4b_error_lit", error, 1);

        stream = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        append_cksum();
        check("t5_cksum_pin", stream[6], 8'h23);
        run_load("t5", 0, stream.size(), 0);
        check("t5_done_lit", done, 1);

        stream[6] = 8'h00;
        run_load("t5b", 0, stream.size(), 0);
        check("t5b_error_lit", error, 1);
        check("t5b_write_issued", wr_count, 1);
        if (act_log.size() == 1) check("t5b_w0", act_log[0], {6'd0, 32'hDEADBEEF});
`endif

        // Full-depth image: last word lands at the top address.
        stream = '{8'h00, 8'h40};
        for (int k = 0; k < 4*DEPTH; k++) stream.push_back(8'((k * 7 + 3) & 8'hFF));
`ifdef IMEM_LOADER_CKSUM_EN
        append_cksum();
`endif
        run_load("t6", 0, stream.size(), 0);
        check("t6_done_lit", done, 1);
        if (act_log.size() == DEPTH) check("t6_last_addr", act_log[DEPTH-1].addr, 63);

        // Reset after five payload bytes, then reload from scratch.
        stream = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`ifdef IMEM_LOADER_CKSUM_EN
        append_cksum();
`endif
        run_load("t7a", 0, 7, 0);
        check("t7a_one_write", wr_count, 1);
        check("t7a_ready_mid", in_ready, 1);
        reset_n = 1'b0;
        #1 check_reset_vals("t7_reset");
        exp_q.delete();
        @(negedge clk); #2 reset_n = 1'b1;
        run_load("t7b", 0, stream.size(), 0);
        check("t7b_log_size", act_log.size(), 2);
        if (act_log.size() == 2) begin
            check("t7b_w0", act_log[0], {6'd0, 32'h12345678});
            check("t7b_w1", act_log[1], {6'd1, 32'h9ABCDEF0});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
